// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - packet-granular round-robin arbiter feeding one byte-serial UART transmitter
// Grant is held from the first byte until the last byte drains, so packets never interleave.
module uart_tx_arb #(
   parameter int num_clients = 4,
   parameter int stall_limit = 1024,
   parameter int ack_limit   = 4
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic [num_clients-1:0]         in_valid,
   input  logic [8*num_clients-1:0]       in_data,
   input  logic [num_clients-1:0]         in_last,
   output logic [num_clients-1:0]         out_ready,
   output logic [7:0]                     out_tx_data,
   output logic                           out_tx_en,
   input  logic                           in_tx_busy,
   output logic [$clog2(num_clients)-1:0] out_grant,
   output logic                           out_active,
   output logic                           out_abort
);

   localparam int gw = $clog2(num_clients);
   localparam int sw = $clog2(stall_limit + 1);
   localparam int aw = $clog2(ack_limit + 1);
   localparam logic [gw-1:0] top_idx = gw'(num_clients - 1);

   typedef enum logic [1:0] {IDLE, SEND, ACK, DRAIN} state_t;

   state_t        state;
   logic [gw-1:0] last_grant;
   logic [gw-1:0] pick_idx;
   logic [gw-1:0] cand;
   logic          pick_found;
   logic [sw-1:0] stall_cnt;
   logic [aw-1:0] ack_cnt;
   logic          last_q;

   // Descending scan so the nearest index after last_grant is the last (winning) write.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = last_grant;
      cand       = last_grant;
      for (int k = num_clients; k >= 1; k--) begin
         cand = gw'((int'(last_grant) + k) % num_clients);
         if (in_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      out_ready = '0;
      if (state == SEND)
         out_ready[out_grant] = in_valid[out_grant];
   end

   assign out_active = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= IDLE;
         out_tx_data <= 8'h00;
         out_tx_en   <= 1'b0;
         out_abort   <= 1'b0;
         out_grant   <= top_idx;
         last_grant  <= top_idx;
         stall_cnt   <= '0;
         ack_cnt     <= '0;
         last_q      <= 1'b0;
      end else begin
         out_tx_en <= 1'b0;
         out_abort <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  out_grant <= pick_idx;
                  stall_cnt <= '0;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (in_valid[out_grant]) begin
                  out_tx_data <= in_data[{out_grant, 3'b000} +: 8];
                  out_tx_en   <= 1'b1;
                  last_q      <= in_last[out_grant];
                  ack_cnt     <= '0;
                  state       <= ACK;
               end else if (stall_cnt == sw'(stall_limit - 1)) begin
                  // Count lands on stall_limit in the cycle out_abort is high.
                  stall_cnt  <= sw'(stall_limit);
                  out_abort  <= 1'b1;
                  last_grant <= out_grant;
                  state      <= IDLE;
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
            end
            ACK: begin
               // Busy may lag tx_en by the transmitter's input register; give up after ack_limit cycles.
               if (in_tx_busy || ack_cnt == aw'(ack_limit - 1))
                  state <= DRAIN;
               else
                  ack_cnt <= ack_cnt + 1'b1;
            end
            DRAIN: begin
               if (!in_tx_busy) begin
                  if (last_q) begin
                     last_grant <= out_grant;
                     state      <= IDLE;
                  end else begin
                     stall_cnt <= '0;
                     state     <= SEND;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - randomized scoreboard bench for uart_tx_arb
module tb_uart_tx_arb;

   localparam int N = 4;
   localparam int S = 20;
   localparam int A = 4;

   typedef struct packed {logic [7:0] d; logic l;} beat_t;
   typedef struct packed {logic [7:0] c; logic [7:0] d;} exp_t;

   logic           clk;
   logic           resetn;
   logic [N-1:0]   in_valid;
   logic [8*N-1:0] in_data;
   logic [N-1:0]   in_last;
   logic [N-1:0]   out_ready;
   logic [7:0]     out_tx_data;
   logic           out_tx_en;
   logic           in_tx_busy;
   logic [1:0]     out_grant;
   logic           out_active;
   logic           out_abort;

   beat_t cq[N][$];
   beat_t st_q[N][$];
   exp_t  exp_q[$];
   int    gap[N];
   bit    gaps_on = 0;
   bit    busy_en = 1;
   bit    busy_rand = 0;
   int    busy_hold = 40;
   int    busy_delay = 2;
   int    model_last = N - 1;
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    tx_count = 0;
   int    abort_cnt = 0;
   int    tx_times[$];
   int    abort_times[$];

   uart_tx_arb #(.num_clients(N), .stall_limit(S), .ack_limit(A)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_ready  (out_ready),
      .out_tx_data(out_tx_data),
      .out_tx_en  (out_tx_en),
      .in_tx_busy (in_tx_busy),
      .out_grant  (out_grant),
      .out_active (out_active),
      .out_abort  (out_abort)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transmitter model: busy rises some cycles after tx_en and holds for a while.
   initial begin
      int hold, dly;
      in_tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (busy_en && out_tx_en) begin
            dly  = busy_rand ? int'($urandom_range(1, 3)) : busy_delay;
            hold = busy_rand ? int'($urandom_range(1, 8)) : busy_hold;
            repeat (dly - 1) @(negedge clk);
            in_tx_busy = 1'b1;
            repeat (hold) @(negedge clk);
            in_tx_busy = 1'b0;
         end
      end
   end

   // Client drivers: present queued beats, hold data until accepted, optional mid-packet gaps.
   initial begin
      logic [N-1:0] hs;
      beat_t b;
      in_valid = '0;
      in_data  = '0;
      in_last  = '0;
      for (int i = 0; i < N; i++) gap[i] = 0;
      forever begin
         @(negedge clk);
         hs = in_valid & out_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (hs[i] && cq[i].size() > 0) begin
               b = cq[i].pop_front();
               if (!b.l && gaps_on) gap[i] = int'($urandom_range(0, S - 4));
            end else if (gap[i] > 0) begin
               gap[i]--;
            end
            if (cq[i].size() > 0 && gap[i] == 0) begin
               in_valid[i]        = 1'b1;
               in_data[8*i +: 8]  = cq[i][0].d;
               in_last[i]         = cq[i][0].l;
            end else begin
               in_valid[i] = 1'b0;
            end
         end
      end
   end

   // Monitor: every tx_en pulse is popped against the scoreboard.
   initial begin
      logic prev_en;
      exp_t e;
      prev_en = 1'b0;
      forever begin
         @(negedge clk);
         if (resetn) begin
            chk("ready_onehot0", 32'($onehot0(out_ready)), 32'd1);
            if (out_ready != '0)
               chk("ready_owner", 32'(out_ready), 32'(1 << out_grant));
            if (out_tx_en) begin
               chk("tx_en_not_back_to_back", 32'(prev_en), 32'd0);
               tx_count++;
               tx_times.push_back(cyc);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL tx_unexpected: got byte %0h from client %0d, expected none", out_tx_data, out_grant);
               end else begin
                  e = exp_q.pop_front();
                  chk("tx_data", 32'(out_tx_data), 32'(e.d));
                  chk("tx_client", 32'(out_grant), 32'(e.c));
               end
            end
            if (out_abort) begin
               abort_cnt++;
               abort_times.push_back(cyc);
            end
         end
         prev_en = out_tx_en;
      end
   end

   task automatic add_pkt(input int c, input int len);
      beat_t b;
      for (int j = 0; j < len; j++) begin
         b.d = 8'($urandom);
         b.l = (j == len - 1);
         st_q[c].push_back(b);
      end
   endtask

   // Reference: every staged client is requesting at once, so packets go out in
   // round-robin order among clients with packets left, starting after model_last.
   task automatic launch();
      int    c;
      bit    any;
      beat_t b;
      exp_t  e;
      any = 1'b1;
      c   = 0;
      while (any) begin
         any = 1'b0;
         for (int k = 1; k <= N && !any; k++) begin
            c = (model_last + k) % N;
            if (st_q[c].size() > 0) any = 1'b1;
         end
         if (any) begin
            do begin
               b = st_q[c].pop_front();
               cq[c].push_back(b);
               e.c = 8'(c);
               e.d = b.d;
               exp_q.push_back(e);
            end while (!b.l);
            model_last = c;
         end
      end
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || out_active || in_tx_busy) && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", 32'(out_active), 32'd0);
      chk("all_bytes_sent", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ready"}, 32'(out_ready), 32'd0);
      chk({tag, "_tx_en"}, 32'(out_tx_en), 32'd0);
      chk({tag, "_tx_data"}, 32'(out_tx_data), 32'd0);
      chk({tag, "_grant"}, 32'(out_grant), 32'(N - 1));
      chk({tag, "_active"}, 32'(out_active), 32'd0);
      chk({tag, "_abort"}, 32'(out_abort), 32'd0);
   endtask

   initial begin
      int    t0, n;
      beat_t b;
      exp_t  e;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      resetn = 1'b1;

      // Contention: clients 0 and 3, two 3-byte packets each.
      add_pkt(0, 3); add_pkt(0, 3); add_pkt(3, 3); add_pkt(3, 3);
      launch();
      wait_idle(2000);
      chk("contention_last_grant", 32'(out_grant), 32'(model_last));

      // Single client with a two-byte packet.
      t0 = tx_count;
      b.d = 8'h41; b.l = 1'b0; st_q[2].push_back(b);
      b.d = 8'h42; b.l = 1'b1; st_q[2].push_back(b);
      launch();
      wait_idle(500);
      chk("single_tx_pulses", 32'(tx_count - t0), 32'd2);
      chk("single_grant", 32'(out_grant), 32'd2);

      // Fairness: all clients with one-byte packets.
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < N; c++) add_pkt(c, 1);
      launch();
      wait_idle(2000);

      // Transmitter that never reports busy.
      busy_en = 1'b0;
      t0 = tx_times.size();
      add_pkt(0, 3);
      launch();
      wait_idle(500);
      chk("nobusy_pulses", 32'(tx_times.size() - t0), 32'd3);
      if (tx_times.size() >= t0 + 3) begin
         chk("nobusy_spacing1", 32'(tx_times[t0+1] - tx_times[t0]), 32'(A + 2));
         chk("nobusy_spacing2", 32'(tx_times[t0+2] - tx_times[t0+1]), 32'(A + 2));
      end

      // Stall: client 1 sends one byte then goes silent; client 2 waits.
      chk("no_abort_before_stall", 32'(abort_cnt), 32'd0);
      t0 = tx_times.size();
      b.d = 8'h5a; b.l = 1'b0; cq[1].push_back(b);
      e.c = 8'd1; e.d = 8'h5a; exp_q.push_back(e);
      n = 0;
      while (!out_tx_en && n < 100) begin @(negedge clk); n++; end
      chk("stall_first_tx", 32'(out_tx_en), 32'd1);
      b.d = 8'hc3; b.l = 1'b1; cq[2].push_back(b);
      e.c = 8'd2; e.d = 8'hc3; exp_q.push_back(e);
      n = 0;
      while (!out_abort && n < 200) begin @(negedge clk); n++; end
      chk("stall_abort_seen", 32'(out_abort), 32'd1);
      chk("abort_in_idle", 32'(out_active), 32'd0);
      @(negedge clk);
      chk("regrant_active", 32'(out_active), 32'd1);
      chk("regrant_client", 32'(out_grant), 32'd2);
      if (abort_times.size() == 1 && tx_times.size() > t0)
         chk("stall_abort_time", 32'(abort_times[0] - tx_times[t0]), 32'(A + S + 1));
      model_last = 2;
      wait_idle(500);
      chk("abort_once", 32'(abort_cnt), 32'd1);

      // Randomized rounds with mid-packet gaps and a jittery transmitter.
      busy_en   = 1'b1;
      busy_rand = 1'b1;
      gaps_on   = 1'b1;
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < N; c++) begin
            n = int'($urandom_range(0, 2));
            for (int p = 0; p < n; p++) add_pkt(c, int'($urandom_range(1, 4)));
         end
         launch();
         wait_idle(4000);
      end
      chk("abort_once_after_random", 32'(abort_cnt), 32'd1);

      // Reset while the grant is waiting in DRAIN.
      busy_rand = 1'b0;
      gaps_on   = 1'b0;
      add_pkt(2, 4);
      launch();
      n = 0;
      while (!(in_tx_busy && out_active) && n < 200) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      chk("pre_reset_active", 32'(out_active), 32'd1);
      resetn = 1'b0;
      for (int i = 0; i < N; i++) begin
         cq[i].delete();
         gap[i] = 0;
      end
      exp_q.delete();
      model_last = N - 1;
      @(negedge clk);
      resetn = 1'b1;
      check_reset("midreset");
      add_pkt(2, 1);
      add_pkt(0, 1);
      launch();
      wait_idle(500);
      chk("post_reset_grant", 32'(out_grant), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      errors++;
      $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
